if_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of the decode stage: owns the PC, drives the

---
 rtl/if_stage_pkg.sv | 8 +
 rtl/if_stage_if_id_reg.sv | 56 +++++
 rtl/if_stage.sv | 74 +++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage and its IF/ID register.
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_STEP       = 32'd4;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds, flushes to a bubble, or loads a fetched instruction.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [31:0] pc_4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_4_q,  pc_4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // Hold beats flush, flush beats load.
    always_comb begin
        pc_4_d  = pc_4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (!hold_i) begin
            if (flush_i) begin
                pc_4_d  = 32'd0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                pc_4_d  = pc_4_i;
                instr_d = instr_i;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_4_q  <= 32'd0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_4_q  <= pc_4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_4_o  = pc_4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux, redirect counter, IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] jumpOrBranchPc,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    input  logic        inst_ready,
    output logic [31:0] pc_4,
    output logic [31:0] instruction,
    output logic        id_valid,
    output logic [15:0] flushCount
);

    // Memory handshake: inst_data is taken only on a cycle where inst_ready=1 and
    // neither stall nor redirect is active; otherwise the word is discarded.
    logic [31:0] pc_q, pc_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        flush;

    assign pc_plus4 = pc_q + PC_STEP;
    assign target   = jumpOrBranchPc & ~32'h0000_0003;
    assign flush    = shouldJumpOrBranch || !inst_ready;

    always_comb begin
        pc_d        = pc_q;
        flush_cnt_d = flush_cnt_q;
        if (shouldStall) begin
            pc_d = pc_q;
        end else if (shouldJumpOrBranch) begin
            pc_d        = target;
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else if (inst_ready) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            flush_cnt_q <= 16'd0;
        end else begin
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (shouldStall),
        .flush_i (flush),
        .pc_4_i  (pc_plus4),
        .instr_i (inst_data),
        .pc_4_o  (pc_4),
        .instr_o (instruction),
        .valid_o (id_valid)
    );

    assign inst_addr  = pc_q;
    assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: default-reset instance plus a wrap-around reset-PC instance.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q[$];

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    // ---- DUT A: RESET_PC = 0 ----
    logic        a_rst, a_stall, a_jb, a_ready, a_valid;
    logic [31:0] a_tgt, a_addr, a_data, a_pc4, a_instr;
    logic [15:0] a_fc;
    assign a_data = mem_word(a_addr);

    if_stage dut_a (
        .clk(clk), .rst(a_rst), .shouldStall(a_stall), .shouldJumpOrBranch(a_jb),
        .jumpOrBranchPc(a_tgt), .inst_addr(a_addr), .inst_data(a_data),
        .inst_ready(a_ready), .pc_4(a_pc4), .instruction(a_instr),
        .id_valid(a_valid), .flushCount(a_fc)
    );

    // ---- DUT B: RESET_PC near the top of the address space ----
    logic        b_rst, b_stall, b_jb, b_ready, b_valid;
    logic [31:0] b_tgt, b_addr, b_data, b_pc4, b_instr;
    logic [15:0] b_fc;
    assign b_data = mem_word(b_addr);

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst(b_rst), .shouldStall(b_stall), .shouldJumpOrBranch(b_jb),
        .jumpOrBranchPc(b_tgt), .inst_addr(b_addr), .inst_data(b_data),
        .inst_ready(b_ready), .pc_4(b_pc4), .instruction(b_instr),
        .id_valid(b_valid), .flushCount(b_fc)
    );

    // ---- checking ----
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected IF/ID contents are queued, then popped against the DUT.
    task automatic expect_ifid(input logic [31:0] pc4, input logic [31:0] instr, input logic valid);
        exp_q.push_back(pc4);
        exp_q.push_back(instr);
        exp_q.push_back({31'd0, valid});
    endtask

    task automatic check_a_ifid(input string tag);
        if (exp_q.size() < 3) begin
            check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd3);
        end else begin
            check_eq({tag, "_pc4"},   a_pc4,               exp_q.pop_front());
            check_eq({tag, "_instr"}, a_instr,             exp_q.pop_front());
            check_eq({tag, "_valid"}, {31'd0, a_valid},    exp_q.pop_front());
        end
    endtask

    // ---- drivers ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic stall, input logic jb, input logic [31:0] tgt,
                           input logic ready);
        a_stall = stall;
        a_jb    = jb;
        a_tgt   = tgt;
        a_ready = ready;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        a_rst = 1'b1; drive_a(1'b0, 1'b0, 32'd0, 1'b1);
        b_rst = 1'b1; b_stall = 1'b0; b_jb = 1'b0; b_tgt = 32'd0; b_ready = 1'b1;

        // reset state
        step(); step();
        check_eq("rst_addr", a_addr, 32'h0);
        check_eq("rst_fc", {16'd0, a_fc}, 32'd0);
        expect_ifid(32'd0, NOP, 1'b0);
        check_a_ifid("rst");

        // free-run fetches from 0
        a_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("run_addr", a_addr, 32'(4 * i));
            step();
            expect_ifid(32'(4 * (i + 1)), mem_word(32'(4 * i)), 1'b1);
            check_a_ifid("run");
        end

        // stall two cycles at pc=8
        drive_a(1'b1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("stall_addr", a_addr, 32'h8);
            expect_ifid(32'h8, mem_word(32'h4), 1'b1);
            check_a_ifid("stall");
        end
        drive_a(1'b0, 1'b0, 32'd0, 1'b1);
        step();
        check_eq("resume_addr", a_addr, 32'hC);
        expect_ifid(32'hC, mem_word(32'h8), 1'b1);
        check_a_ifid("resume");
        step();
        expect_ifid(32'h10, mem_word(32'hC), 1'b1);
        check_a_ifid("run4");
        check_eq("pre_redir_addr", a_addr, 32'h10);

        // redirect to 0x40
        drive_a(1'b0, 1'b1, 32'h40, 1'b1);
        step();
        check_eq("redir_addr", a_addr, 32'h40);
        check_eq("redir_fc", {16'd0, a_fc}, 32'd1);
        expect_ifid(32'd0, NOP, 1'b0);
        check_a_ifid("redir");
        drive_a(1'b0, 1'b0, 32'd0, 1'b1);
        step();
        expect_ifid(32'h44, mem_word(32'h40), 1'b1);
        check_a_ifid("target");

        // redirect to 0x20, then three wait states
        drive_a(1'b0, 1'b1, 32'h20, 1'b1);
        step();
        check_eq("redir2_fc", {16'd0, a_fc}, 32'd2);
        drive_a(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("wait_addr", a_addr, 32'h20);
            expect_ifid(32'd0, NOP, 1'b0);
            check_a_ifid("wait");
        end
        drive_a(1'b0, 1'b0, 32'd0, 1'b1);
        step();
        check_eq("wait_done_addr", a_addr, 32'h24);
        expect_ifid(32'h24, mem_word(32'h20), 1'b1);
        check_a_ifid("wait_done");

        // stall together with redirect: redirect ignored
        drive_a(1'b1, 1'b1, 32'h80, 1'b1);
        step();
        check_eq("stallredir_addr", a_addr, 32'h24);
        check_eq("stallredir_fc", {16'd0, a_fc}, 32'd2);
        expect_ifid(32'h24, mem_word(32'h20), 1'b1);
        check_a_ifid("stallredir");

        // redirect during a memory wait, unaligned target
        drive_a(1'b0, 1'b1, 32'h103, 1'b0);
        step();
        check_eq("waitredir_addr", a_addr, 32'h100);
        check_eq("waitredir_fc", {16'd0, a_fc}, 32'd3);
        expect_ifid(32'd0, NOP, 1'b0);
        check_a_ifid("waitredir");

        // reset mid-wait wins; first fetch at 0 afterwards
        drive_a(1'b0, 1'b0, 32'd0, 1'b0);
        a_rst = 1'b1;
        step();
        check_eq("midrst_addr", a_addr, 32'h0);
        check_eq("midrst_fc", {16'd0, a_fc}, 32'd0);
        a_rst = 1'b0;
        drive_a(1'b0, 1'b0, 32'd0, 1'b1);
        step();
        expect_ifid(32'h4, mem_word(32'h0), 1'b1);
        check_a_ifid("postrst");

        // DUT B: PC wrap and target alignment
        check_eq("b_rst_addr", b_addr, 32'hFFFF_FFF8);
        b_rst = 1'b0;
        step();
        check_eq("b_addr1", b_addr, 32'hFFFF_FFFC);
        check_eq("b_pc4_1", b_pc4, 32'hFFFF_FFFC);
        step();
        check_eq("b_addr2", b_addr, 32'h0);
        check_eq("b_pc4_2", b_pc4, 32'h0);
        check_eq("b_instr2", b_instr, mem_word(32'hFFFF_FFFC));
        check_eq("b_valid2", {31'd0, b_valid}, 32'd1);
        b_jb = 1'b1; b_tgt = 32'h33;
        step();
        check_eq("b_redir_addr", b_addr, 32'h30);
        check_eq("b_redir_fc", {16'd0, b_fc}, 32'd1);
        b_jb = 1'b0;
        step();
        check_eq("b_target_pc4", b_pc4, 32'h34);
        check_eq("b_target_instr", b_instr, mem_word(32'h30));

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
